bcd_subtractor_serial: RTL

- Digit-serial, multi-digit packed-BCD subtractor. It is the subtract-direction companion to the team's BCD adder.
- Computes the sign-magnitude result of A - B, processing one BCD digit per clock, LSD first.
- A 10's-complement correction pass runs when the raw result is negative.
- Used wherever decimal counters/accumulators need difference or compare-with-magnitude, behind a start/busy/done handshake.

---
 rtl/bcd_subtractor_serial.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: sign-magnitude |A-B| one digit per clock, LSD first.
// A negative raw result (final borrow set) gets a 10's-complement pass before done.
module bcd_subtractor_serial #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  neg,
   output logic                  err
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(DIGITS - 1);

   typedef enum logic [1:0] {StIdle, StSub, StComp, StFin} state_e;

   state_e         state_q;
   logic [IW-1:0]  idx_q;
   logic           borrow_q;   // borrow in SUB, carry in COMP
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   diff_q;
   logic           busy_q;
   logic           done_q;
   logic           neg_q;
   logic           err_q;

   logic           bad_operand;
   logic [4:0]     sub_raw;
   logic           sub_neg;
   logic [3:0]     sub_digit;
   logic [4:0]     comp_raw;
   logic           comp_carry;
   logic [3:0]     comp_digit;

   // Flag any non-decimal nibble on either operand input.
   always_comb begin
      bad_operand = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
            bad_operand = 1'b1;
         end
      end
   end

   // Per-digit arithmetic on the low nibbles; operands and diff rotate through bit 0.
   always_comb begin
      sub_raw    = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, borrow_q};
      sub_neg    = sub_raw[4];
      // Adding 10 modulo 16 to the two's-complement low nibble yields t + 10.
      sub_digit  = sub_neg ? (sub_raw[3:0] + 4'd10) : sub_raw[3:0];
      comp_raw   = {1'b0, 4'd9 - diff_q[3:0]} + {4'b0, borrow_q};
      comp_carry = (comp_raw > 5'd9);
      comp_digit = comp_carry ? 4'(comp_raw - 5'd10) : comp_raw[3:0];
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  diff_q   <= '0;
                  neg_q    <= 1'b0;
                  err_q    <= bad_operand;
                  idx_q    <= '0;
                  borrow_q <= 1'b0;
                  busy_q   <= ~bad_operand;
                  done_q   <= bad_operand;
                  state_q  <= bad_operand ? StFin : StSub;
               end
            end
            StSub: begin
               // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
               diff_q   <= W'({sub_digit, diff_q} >> 4);
               a_q      <= a_q >> 4;
               b_q      <= b_q >> 4;
               borrow_q <= sub_neg;
               idx_q    <= idx_q + IW'(1);
               if (idx_q == LastIdx) begin
                  idx_q <= '0;
                  if (sub_neg) begin
                     neg_q    <= 1'b1;
                     borrow_q <= 1'b1;   // complement pass starts with carry 1
                     state_q  <= StComp;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StFin;
                  end
               end
            end
            StComp: begin
               diff_q   <= W'({comp_digit, diff_q} >> 4);
               borrow_q <= comp_carry;
               idx_q    <= idx_q + IW'(1);
               if (idx_q == LastIdx) begin
                  idx_q    <= '0;
                  borrow_q <= 1'b0;   // final carry discarded
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= StFin;
               end
            end
            StFin: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign neg  = neg_q;
   assign err  = err_q;

endmodule
